lfsr_engine: RTL and testbench

LFSR_ENGINE -- requirements
Module: lfsr_engine

---
 rtl/lfsr_pkg.sv | 17 +
 rtl/lfsr_engine_if.sv | 33 +++
 rtl/lfsr_step.sv | 30 +++
 rtl/lfsr_engine.sv | 108 ++++++++++
 tb/tb_lfsr_engine.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared types for the LFSR engine.
//   lfsr_type_e : feedback structure selected by configuration
//   lfsr_fsm_e  : controller states (RUN, LOAD, LOCK)
package lfsr_pkg;

    typedef enum logic {
        FIBONACCI = 1'b0,
        GALOIS    = 1'b1
    } lfsr_type_e;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        LOCK = 2'd2
    } lfsr_fsm_e;

endpackage

// File: rtl/lfsr_engine_if.sv
// Bus bundle between the LFSR engine and its user.
//   en                         : permit word generation
//   cfg_valid/cfg_ready        : configuration handshake carrying cfg_type, cfg_taps, cfg_seed
//   out_valid/out_ready        : output word handshake carrying out_data
//   state, lockup, period_done : status
// master = user side, slave = engine side.
interface lfsr_engine_if #(
    parameter int LENGTH = 16,
    parameter int OUT_W  = 1
);
    logic              en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              cfg_type;
    logic [LENGTH-1:0] cfg_taps;
    logic [LENGTH-1:0] cfg_seed;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [LENGTH-1:0] state;
    logic              lockup;
    logic              period_done;

    modport master (
        output en, cfg_valid, cfg_type, cfg_taps, cfg_seed, out_ready,
        input  cfg_ready, out_valid, out_data, state, lockup, period_done
    );

    modport slave (
        input  en, cfg_valid, cfg_type, cfg_taps, cfg_seed, out_ready,
        output cfg_ready, out_valid, out_data, state, lockup, period_done
    );
endinterface

// File: rtl/lfsr_step.sv
// One combinational LFSR step.
//   kind    : FIBONACCI or GALOIS
//   taps    : tap mask, bit 0 = input end
//   cur     : state before the step
//   nxt     : state after the step
//   bit_out : bit shifted out (cur[LENGTH-1])
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int LENGTH = 16
) (
    input  lfsr_type_e        kind,
    input  logic [LENGTH-1:0] taps,
    input  logic [LENGTH-1:0] cur,
    output logic [LENGTH-1:0] nxt,
    output logic              bit_out
);
    logic [LENGTH-1:0] toggled;

    always_comb begin
        bit_out = cur[LENGTH-1];
        toggled = cur ^ (taps & {LENGTH{cur[LENGTH-1]}});
        if (kind == GALOIS) begin
            // rotate toward the output end; the top bit wraps to the input end
            nxt = {toggled[LENGTH-2:0], toggled[LENGTH-1]};
        end else begin
            nxt = {cur[LENGTH-2:0], ^(taps & cur)};
        end
    end
endmodule

// File: rtl/lfsr_engine.sv
// Configurable Fibonacci/Galois LFSR producing OUT_W bits per clock.
//   clk : clock, rising edge
//   rst : asynchronous reset, active low
//   bus : lfsr_engine_if slave (enable, config handshake, output handshake, status)
//
// state | meaning
// RUN   | generate words while enabled and the output slot is free
// LOAD  | one cycle: install captured seed, drop pending word
// LOCK  | all-zero state, no generation until a new config arrives
module lfsr_engine
    import lfsr_pkg::*;
#(
    parameter int                LENGTH   = 16,
    parameter int                OUT_W    = 1,
    parameter int                DEF_TYPE = 0,
    parameter logic [LENGTH-1:0] DEF_TAPS = LENGTH'(16'b0110100000000001),
    parameter logic [LENGTH-1:0] DEF_SEED = LENGTH'(1)
) (
    input logic          clk,
    input logic          rst,
    lfsr_engine_if.slave bus
);
    lfsr_fsm_e         fsm;
    lfsr_type_e        kind;
    logic [LENGTH-1:0] taps;
    logic [LENGTH-1:0] lfsr;
    logic [LENGTH-1:0] seed_reg;
    logic [LENGTH-1:0] cap_seed;
    logic              out_valid_q;
    logic [OUT_W-1:0]  out_data_q;
    logic              lockup_q;
    logic              period_done_q;

    logic [OUT_W:0][LENGTH-1:0] chain;
    logic [OUT_W-1:0]           word_bits;
    logic                       cfg_fire;
    logic                       accept;
    logic                       gen;

    assign chain[0] = lfsr;

    for (genvar k = 0; k < OUT_W; k++) begin : g_step
        lfsr_step #(.LENGTH(LENGTH)) u_step (
            .kind    (kind),
            .taps    (taps),
            .cur     (chain[k]),
            .nxt     (chain[k+1]),
            .bit_out (word_bits[k])
        );
    end

    assign bus.cfg_ready   = (fsm != LOAD);
    assign cfg_fire        = bus.cfg_valid && (fsm != LOAD);
    assign accept          = out_valid_q && bus.out_ready;
    assign gen             = bus.en && (!out_valid_q || bus.out_ready);
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.state       = lfsr;
    assign bus.lockup      = lockup_q;
    assign bus.period_done = period_done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm           <= RUN;
            kind          <= (DEF_TYPE != 0) ? GALOIS : FIBONACCI;
            taps          <= DEF_TAPS;
            lfsr          <= DEF_SEED;
            seed_reg      <= DEF_SEED;
            cap_seed      <= DEF_SEED;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            lockup_q      <= 1'b0;
            period_done_q <= 1'b0;
        end else begin
            period_done_q <= 1'b0;
            case (fsm)
                LOAD: begin
                    lfsr        <= cap_seed;
                    seed_reg    <= cap_seed;
                    out_valid_q <= 1'b0;
                    lockup_q    <= (cap_seed == '0);
                    fsm         <= (cap_seed == '0) ? LOCK : RUN;
                end
                default: begin
                    // config beats word generation; an accepted word still counts as consumed
                    if (cfg_fire) begin
                        fsm      <= LOAD;
                        kind     <= lfsr_type_e'(bus.cfg_type);
                        taps     <= bus.cfg_taps;
                        cap_seed <= bus.cfg_seed;
                        if (accept) out_valid_q <= 1'b0;
                    end else if (fsm == RUN && gen) begin
                        lfsr        <= chain[OUT_W];
                        out_data_q  <= word_bits;
                        out_valid_q <= 1'b1;
                        if (chain[OUT_W] == '0) begin
                            fsm      <= LOCK;
                            lockup_q <= 1'b1;
                        end
                        if (chain[OUT_W] == seed_reg) period_done_q <= 1'b1;
                    end else if (accept) begin
                        out_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lfsr_engine.sv
module tb_lfsr_engine;
    import lfsr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lfsr_engine_if #(.LENGTH(4),  .OUT_W(1)) bus_a ();
    lfsr_engine_if #(.LENGTH(4),  .OUT_W(4)) bus_b ();
    lfsr_engine_if #(.LENGTH(16), .OUT_W(1)) bus_c ();

    lfsr_engine #(.LENGTH(4),  .OUT_W(1))               dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    lfsr_engine #(.LENGTH(4),  .OUT_W(4))               dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    lfsr_engine #(.LENGTH(16), .OUT_W(1), .DEF_TYPE(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    // b sees exactly the same stimulus as a
    assign bus_b.en        = bus_a.en;
    assign bus_b.cfg_valid = bus_a.cfg_valid;
    assign bus_b.cfg_type  = bus_a.cfg_type;
    assign bus_b.cfg_taps  = bus_a.cfg_taps;
    assign bus_b.cfg_seed  = bus_a.cfg_seed;
    assign bus_b.out_ready = bus_a.out_ready;

    typedef struct {
        logic [3:0] data;
        logic [3:0] st;
        bit         pd;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int n_vec = 0;
    int n_err = 0;

    bit         mgal;
    logic [3:0] mtaps, seed_m, ma, mb, la, lb;
    bit         ova, ovb, run_m, lock_m;
    int         wa, wb, pwa, pwb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mstep(input bit gal, input logic [15:0] tp,
                                          input logic [15:0] st, input int len, output bit emit);
        logic [15:0] mask, t, nx;
        mask = 16'hFFFF >> (16 - len);
        emit = st[len-1];
        if (gal) begin
            t  = (st ^ (emit ? tp : 16'h0)) & mask;
            nx = ((t << 1) | {15'b0, t[len-1]}) & mask;
        end else begin
            nx = ((st << 1) | {15'b0, ^(tp & st & mask)}) & mask;
        end
        return nx;
    endfunction

    task automatic cyc(input bit en_i, input bit rdy_i);
        exp_t        ea, eb;
        bit          pa, pb, b;
        logic [15:0] s;
        bus_a.en        = en_i;
        bus_a.out_ready = rdy_i;
        bus_a.cfg_valid = 1'b0;
        pa = en_i && run_m && (!ova || rdy_i);
        pb = en_i && run_m && (!ovb || rdy_i);
        if (pa) begin
            s = mstep(mgal, {12'b0, mtaps}, {12'b0, ma}, 4, b);
            ea.data = {3'b0, b};
            ea.st   = s[3:0];
            ea.pd   = (s[3:0] == seed_m);
            qa.push_back(ea);
            ma = s[3:0]; la = ea.data; ova = 1'b1;
        end else if (ova && rdy_i) ova = 1'b0;
        if (pb) begin
            s = {12'b0, mb};
            eb.data = '0;
            for (int k = 0; k < 4; k++) begin
                s = mstep(mgal, {12'b0, mtaps}, s, 4, b);
                eb.data[k] = b;
            end
            eb.st = s[3:0];
            eb.pd = (s[3:0] == seed_m);
            qb.push_back(eb);
            mb = s[3:0]; lb = eb.data; ovb = 1'b1;
        end else if (ovb && rdy_i) ovb = 1'b0;
        tick();
        chk("a_valid", bus_a.out_valid, ova);
        chk("b_valid", bus_b.out_valid, ovb);
        chk("a_lockup", bus_a.lockup, lock_m);
        if (pa) begin
            ea = qa.pop_front();
            wa++;
            if (ea.pd && pwa == 0) pwa = wa;
            chk("a_data", bus_a.out_data, ea.data);
            chk("a_state", bus_a.state, ea.st);
            chk("a_period", bus_a.period_done, ea.pd);
        end else begin
            chk("a_state_hold", bus_a.state, ma);
            chk("a_period_idle", bus_a.period_done, 1'b0);
            if (ova) chk("a_data_hold", bus_a.out_data, la);
        end
        if (pb) begin
            eb = qb.pop_front();
            wb++;
            if (eb.pd && pwb == 0) pwb = wb;
            chk("b_data", bus_b.out_data, eb.data);
            chk("b_state", bus_b.state, eb.st);
            chk("b_period", bus_b.period_done, eb.pd);
        end else begin
            chk("b_state_hold", bus_b.state, mb);
            if (ovb) chk("b_data_hold", bus_b.out_data, lb);
        end
    endtask

    task automatic cfg(input bit gal, input logic [3:0] tp, input logic [3:0] seed,
                       input bit en_i, input bit rdy_i);
        bus_a.cfg_valid = 1'b1;
        bus_a.cfg_type  = gal;
        bus_a.cfg_taps  = tp;
        bus_a.cfg_seed  = seed;
        bus_a.en        = en_i;
        bus_a.out_ready = rdy_i;
        ova = ova && !rdy_i;
        ovb = ovb && !rdy_i;
        tick();
        chk("cfg_ready_load", bus_a.cfg_ready, 1'b0);
        chk("cfg_a_valid", bus_a.out_valid, ova);
        chk("cfg_a_state_hold", bus_a.state, ma);
        chk("cfg_a_period", bus_a.period_done, 1'b0);
        bus_a.cfg_valid = 1'b0;
        tick();
        mgal = gal; mtaps = tp; seed_m = seed; ma = seed; mb = seed;
        ova = 1'b0; ovb = 1'b0;
        lock_m = (seed == 4'b0000);
        run_m = !lock_m;
        wa = 0; wb = 0; pwa = 0; pwb = 0;
        chk("load_a_state", bus_a.state, seed);
        chk("load_b_state", bus_b.state, seed);
        chk("load_a_valid", bus_a.out_valid, 1'b0);
        chk("load_a_lockup", bus_a.lockup, lock_m);
        chk("load_cfg_ready", bus_a.cfg_ready, 1'b1);
    endtask

    initial begin
        logic [15:0] mc, nc;
        bit          bc;
        int          pc;
        logic [3:0]  exp_bits;
        logic [3:0]  exp_st [3];

        bus_a.en = 1'b0; bus_a.cfg_valid = 1'b0; bus_a.cfg_type = 1'b0;
        bus_a.cfg_taps = '0; bus_a.cfg_seed = '0; bus_a.out_ready = 1'b0;
        bus_c.en = 1'b0; bus_c.cfg_valid = 1'b0; bus_c.cfg_type = 1'b0;
        bus_c.cfg_taps = '0; bus_c.cfg_seed = '0; bus_c.out_ready = 1'b0;
        exp_bits = 4'b1000;
        exp_st[0] = 4'b0010; exp_st[1] = 4'b0100; exp_st[2] = 4'b1001;

        #12;
        chk("rst_a_state", bus_a.state, 4'b0001);
        chk("rst_a_valid", bus_a.out_valid, 1'b0);
        chk("rst_a_data", bus_a.out_data, 1'b0);
        chk("rst_a_lockup", bus_a.lockup, 1'b0);
        chk("rst_a_period", bus_a.period_done, 1'b0);
        chk("rst_a_cfg_ready", bus_a.cfg_ready, 1'b1);
        chk("rst_c_state", bus_c.state, 16'h0001);

        @(negedge clk);
        rst = 1'b1;
        mgal = 1'b0; mtaps = 4'b0001; seed_m = 4'b0001; ma = 4'b0001; mb = 4'b0001;
        la = '0; lb = '0; ova = 1'b0; ovb = 1'b0; run_m = 1'b1; lock_m = 1'b0;
        wa = 0; wb = 0; pwa = 0; pwb = 0;

        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);

        // Fibonacci, taps index 2,3, seed index 0
        cfg(1'b0, 4'b1100, 4'b0001, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b1);
            if (i < 4) chk("a_fixed_bit", bus_a.out_data, exp_bits[i]);
            if (i < 3) chk("a_fixed_state", bus_a.state, exp_st[i]);
            if (i == 0) begin
                chk("b_first_word", bus_b.out_data, 4'b1000);
                chk("b_first_state", bus_b.state, 4'b0011);
            end
        end
        chk("a_period_word", pwa, 15);
        chk("b_period_word", pwb, 15);

        // stall, then resume
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);

        // config coinciding with acceptance
        cyc(1'b1, 1'b1);
        cfg(1'b0, 4'b1100, 4'b0110, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);

        // config while a word is stalled
        cyc(1'b1, 1'b0);
        cfg(1'b0, 4'b1100, 4'b1010, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);

        // all-zero seed locks, a valid seed recovers
        cfg(1'b0, 4'b1100, 4'b0000, 1'b1, 1'b1);
        chk("lock_cfg_ready", bus_a.cfg_ready, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        cfg(1'b0, 4'b1100, 4'b0001, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);

        // maximal-length Galois on the small instances
        cfg(1'b1, 4'b0100, 4'b0001, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1);
        chk("a_galois_period", pwa, 15);
        bus_a.en = 1'b0;

        // 16-bit Galois from reset defaults, run until the seed comes back
        bus_c.out_ready = 1'b1;
        bus_c.en = 1'b1;
        mc = 16'h0001;
        pc = 0;
        for (int n = 1; n <= 65535; n++) begin
            nc = mstep(1'b1, 16'b0110100000000001, mc, 16, bc);
            tick();
            chk("c_state", bus_c.state, nc);
            chk("c_period", bus_c.period_done, (nc == 16'h0001));
            mc = nc;
            if (nc == 16'h0001) begin
                pc = n;
                break;
            end
        end
        chk("c_period_seen", (pc != 0), 1'b1);

        // asynchronous reset in the middle of a run
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_c_state", bus_c.state, 16'h0001);
        chk("arst_c_valid", bus_c.out_valid, 1'b0);
        chk("arst_c_data", bus_c.out_data, 1'b0);
        chk("arst_c_lockup", bus_c.lockup, 1'b0);
        chk("arst_c_period", bus_c.period_done, 1'b0);
        chk("arst_c_cfg_ready", bus_c.cfg_ready, 1'b1);
        chk("arst_a_state", bus_a.state, 4'b0001);
        bus_c.en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_rst_c_period", bus_c.period_done, 1'b0);
        chk("post_rst_c_valid", bus_c.out_valid, 1'b0);
        chk("post_rst_c_state", bus_c.state, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
